// File: rtl/vector_sub_pipe.sv
// Purpose : N-lane unsigned vector subtractor a[i] = y[i] - b[i] (mod 2^W), two-stage pipeline.
// Latency : vector accepted at edge k is visible at the output after edge k+1.
// Backpr. : valid/ready, 2-deep; in_ready is combinational from out_ready so a full pipe drains and refills at one edge.
//
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready - input handshake for y (minuend) and b (subtrahend) lanes
//   out_valid/out_ready - output handshake for a (difference) lanes
//   borrow            - per-lane borrow (y < b), only when VSUB_BORROW_EN is defined
//
// Optional feature macro: VSUB_BORROW_EN
module vector_sub_pipe #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] y [N-1:0],
    input  logic [W-1:0] b [N-1:0],
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a [N-1:0]
`ifdef VSUB_BORROW_EN
    ,
    output logic [N-1:0] borrow
`endif
);

    logic         s1_valid;
    logic         s2_valid;
    logic         s1_adv;
    logic         s2_adv;
    logic         s1_load;
    logic         s2_load;
    logic [W-1:0] y_r [N-1:0];
    logic [W-1:0] b_r [N-1:0];
    logic [W-1:0] a_r [N-1:0];

    // A stage may advance when it is empty or its contents leave this cycle.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = in_valid && s1_adv;
    assign s2_load  = s1_valid && s2_adv;

    // Stage 1: capture operands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                y_r[i] <= '0;
                b_r[i] <= '0;
            end
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                for (int i = 0; i < N; i++) begin
                    y_r[i] <= y[i];
                    b_r[i] <= b[i];
                end
            end
        end
    end

    // Stage 2: register the per-lane difference; lanes never interact.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_r[i] <= '0;
            end
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_load) begin
                for (int i = 0; i < N; i++) begin
                    a_r[i] <= y_r[i] - b_r[i];
                end
            end
        end
    end

`ifdef VSUB_BORROW_EN
    logic [N-1:0] borrow_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            borrow_r <= '0;
        end else if (s2_load) begin
            for (int i = 0; i < N; i++) begin
                borrow_r[i] <= (y_r[i] < b_r[i]);
            end
        end
    end

    assign borrow = borrow_r;
`endif

    assign out_valid = s2_valid;
    assign a         = a_r;

endmodule

// File: tb/tb_vector_sub_pipe.sv
// Purpose : self-checking bench for vector_sub_pipe against a queue-based reference model.
// Latency : expects results two edges after acceptance when the output is not stalled.
// Backpr. : drives random/held out_ready and checks stall hold, capacity and ordering.
module tb_vector_sub_pipe;

    localparam int W = 8;
    localparam int N = 4;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y [N-1:0];
    logic [W-1:0] b [N-1:0];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a [N-1:0];
`ifdef VSUB_BORROW_EN
    logic [N-1:0] borrow;
`endif

    vector_sub_pipe #(.W(W), .N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a)
`ifdef VSUB_BORROW_EN
        ,
        .borrow    (borrow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [N*W-1:0] diff;
        logic [N-1:0]   bor;
        int             acyc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic           acc;
    logic           fire;
    logic           samp_ov;
    logic           samp_rdy;
    logic [N*W-1:0] samp_a;
    logic [N*W-1:0] last_a;
    logic [N-1:0]   last_bor;
    logic           lat_chk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack_a();
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = a[i];
        return p;
    endfunction

    // Reference: plain integer subtraction folded into [0, 2^W).
    function automatic exp_t model();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            int d;
            d = int'(y[i]) - int'(b[i]);
            e.bor[i] = (d < 0);
            if (d < 0) d = d + (1 << W);
            e.diff[i*W +: W] = d[W-1:0];
        end
        e.acyc = cyc;
        return e;
    endfunction

    // One clock cycle: entered at posedge+1 with inputs driven, samples at posedge+4.
    task automatic tick();
        exp_t e;
        #3;
        acc      = in_valid && in_ready;
        fire     = out_valid && out_ready;
        samp_ov  = out_valid;
        samp_rdy = in_ready;
        samp_a   = pack_a();
        if (fire) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                last_a = samp_a;
                check_eq("data", samp_a, e.diff);
`ifdef VSUB_BORROW_EN
                last_bor = borrow;
                check_eq("borrow", borrow, e.bor);
`endif
                if (lat_chk) check_eq("latency", cyc - e.acyc, 2);
            end
        end
        if (acc) exp_q.push_back(model());
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    // Send one vector with out_ready high and wait for its result.
    task automatic send_one(input logic [N*W-1:0] yv, input logic [N*W-1:0] bv);
        int n;
        logic got;
        for (int i = 0; i < N; i++) begin
            y[i] = yv[i*W +: W];
            b[i] = bv[i*W +: W];
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check_eq("accept", acc, 1'b1);
        in_valid = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 6) begin
            tick();
            got = fire;
            n++;
        end
        check_eq("result_seen", got, 1'b1);
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < N; i++) begin
            y[i] = W'($urandom);
            b[i] = W'($urandom);
        end
    endtask

    initial begin
        int nacc;
        int sent;
        int guard;
        logic [N*W-1:0] prev;
        logic have_prev;

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        lat_chk   = 1'b0;
        acc       = 1'b0;
        fire      = 1'b0;
        last_a    = '0;
        last_bor  = '0;
        for (int i = 0; i < N; i++) begin
            y[i] = '0;
            b[i] = '0;
        end

        // Reset state.
        #12;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_a", pack_a(), '0);
`ifdef VSUB_BORROW_EN
        check_eq("rst_borrow", borrow, '0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Directed vector: y={10,200,0,255}, b={3,100,1,255} (lane 3 first).
        lat_chk = 1'b1;
        send_one({8'd10, 8'd200, 8'd0, 8'd255}, {8'd3, 8'd100, 8'd1, 8'd255});
        check_eq("dir_a", last_a, 32'h0764FF00);
`ifdef VSUB_BORROW_EN
        check_eq("dir_borrow", last_bor, 4'b0010);
`endif

        // Wrap-around.
        send_one(32'h00000000, {8'd1, 8'd128, 8'd255, 8'd0});
        check_eq("wrap_a", last_a, 32'hFF800100);
`ifdef VSUB_BORROW_EN
        check_eq("wrap_borrow", last_bor, 4'b1110);
`endif
        drain();

        // Streaming: 16 back-to-back vectors, every lane result equals its index.
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < N; i++) begin
                y[i] = W'(k + i);
                b[i] = W'(k);
            end
            in_valid = 1'b1;
            tick();
            check_eq("stream_ready", samp_rdy, 1'b1);
            if (k >= 2) check_eq("stream_lane2", samp_a[2*W +: W], 2);
        end
        drain();
        lat_chk = 1'b0;

        // Backpressure: three distinct vectors against a stalled output.
        out_ready = 1'b0;
        nacc      = 0;
        have_prev = 1'b0;
        prev      = '0;
        for (int i = 0; i < N; i++) begin
            y[i] = W'(50 + i);
            b[i] = W'(i);
        end
        in_valid = 1'b1;
        repeat (6) begin
            tick();
            if (samp_ov && have_prev) check_eq("stall_a", samp_a, prev);
            if (samp_ov) begin
                prev      = samp_a;
                have_prev = 1'b1;
            end
            if (acc) begin
                nacc++;
                for (int i = 0; i < N; i++) begin
                    y[i] = W'(50 + 20 * nacc + i);
                    b[i] = W'(nacc);
                end
            end
        end
        check_eq("bp_accepted", nacc, 2);
        check_eq("bp_in_ready", samp_rdy, 1'b0);
        check_eq("bp_out_valid", samp_ov, 1'b1);
        // Release: held third vector is accepted at the same edge the pipe drains.
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_acc", acc, 1'b1);
        drain();

        // Randomised traffic against the model.
        in_valid = 1'b0;
        acc      = 1'b0;
        sent     = 0;
        guard    = 0;
        while (sent < 1000 && guard < 20000) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_lanes();
            end
            out_ready = $urandom_range(0, 1) == 1;
            tick();
            if (acc) sent++;
            guard++;
        end
        check_eq("rand_sent", sent, 1000);
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_lanes();
        repeat (3) begin
            tick();
            if (acc) rand_lanes();
        end
        check_eq("pre_rst_full", samp_rdy, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_a", pack_a(), '0);
        check_eq("midrst_in_ready", in_ready, 1'b1);
`ifdef VSUB_BORROW_EN
        check_eq("midrst_borrow", borrow, '0);
`endif
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        reset = 1'b1;
        lat_chk = 1'b1;
        send_one({8'd9, 8'd9, 8'd9, 8'd9}, {8'd1, 8'd2, 8'd3, 8'd4});
        check_eq("post_rst_a", last_a, 32'h08070605);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard against a wedged run.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vector_sub_pipe.md
# vector_sub_pipe

Pipelined N-lane vector subtractor with valid/ready handshakes: it takes a sum vector `y` and an operand vector `b` and returns `a = y - b` per lane. It is the inverse of the registered vector adder and sits on the adder's output side to recover one operand for checking and decomposition. A two-stage pipeline (input register, result register) sustains one vector per cycle and propagates backpressure.

## Interface
- `W`, default 8: lane width in bits.
- `N`, default 4: number of lanes.
- `clock`  input  1: sole clock, rising edge.
- `reset`  input  1: asynchronous, active-low reset (asserts on the falling edge; release is synchronous to `clock` externally).
- `in_valid`  input  1: `y`/`b` carry a valid vector.
- `in_ready`  output  1: block accepts the vector this cycle.
- `y`  input  [W-1:0] x N (unpacked array `[N-1:0]`): minuend lanes.
- `b`  input  [W-1:0] x N: subtrahend lanes.
- `out_valid`  output  1: `a` holds a valid result.
- `out_ready`  input  1: the consumer takes the result this cycle.
- `a`  output  [W-1:0] x N: difference lanes.
- `borrow`  output  [N-1:0]: per-lane borrow; present only with `VSUB_BORROW_EN`.

## Operation
- Stage 1 (S1) registers: `y_r[i]`, `b_r[i]`, `s1_valid`. Stage 2 (S2) registers: `a_r[i]`, `s2_valid` (plus `borrow_r` when enabled).
- Lane math: `a[i] = (y[i] - b[i]) mod 2^W`, unsigned, independent per lane. There is no carry between lanes.
- Borrow: `borrow[i] = (y_r[i] < b_r[i])`, unsigned compare, registered with `a_r[i]`.
- Advance rules, evaluated each cycle:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv`. This path is combinational from `out_ready`; that is intended.
- S1 loads when `in_valid && in_ready`. `s1_valid` takes `in_valid` whenever `s1_adv`.
- S2 loads the S1 difference when `s1_valid && s2_adv`. `s2_valid` takes `s1_valid` whenever `s2_adv`.
- Data registers update only on a load. On a bubble they hold their previous value; contents are don't-care while the matching valid is low.
- `out_valid = s2_valid`, `a = a_r`.
- Stall hold: while `out_valid && !out_ready`, `a`, `borrow` and `out_valid` stay stable. S1 holds as well once it is full.
- Reset asserted (`reset == 0`):
  - Clears `s1_valid`, `s2_valid`, all data registers and `borrow_r` to 0 immediately.
  - Any vectors in flight are discarded.
  - `in_ready` reads 1 during reset.

## Timing
- Latency: a vector accepted at edge k is presented with `out_valid = 1` after edge k+1, provided the output path is not stalled.
- Throughput: one vector per cycle while `out_ready` stays high.
- Buffering capacity: 2 vectors. With `out_ready` held low, exactly two vectors are accepted, then `in_ready` drops.
- `out_ready` rising with both stages full: S2 drains, S1 moves to S2 and a new input is accepted, all at the same edge. No bubble, no loss.
- `in_valid` high with `in_ready` low: the input is not captured, and the source must hold it.
- Reset values: `out_valid = 0`, `a = 0` on every lane, `borrow = 0`, `in_ready = 1`.

## Configuration
- `VSUB_BORROW_EN` defined: the `borrow` port and `borrow_r` registers exist and follow the rules above.
- Not defined: the `borrow` port and its registers are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then one vector `y = {10, 200, 0, 255}`, `b = {3, 100, 1, 255}` with `out_ready = 1`. Expect `out_valid` high 2 edges after acceptance, `a = {7, 100, 255, 0}`, `borrow = {0, 0, 1, 0}`.
- Streaming: 16 back-to-back vectors with `y[i] = k + i` and `b[i] = k`, `out_ready = 1`. Expect `in_ready` high throughout, every result lane equal to `i`, in order, one per cycle.
- Backpressure: `out_ready = 0` while `in_valid = 1` with 3 distinct vectors. Expect only 2 accepted, `in_ready = 0` afterwards, `a` stable. Raising `out_ready` yields all 3 in order with no duplicates.
- Random `out_ready` (50%) with random `in_valid` over 1000 vectors against a reference model. Expect zero mismatches, no drops and no reordering.
- Reset mid-stream with both stages full: drive `reset = 0` between edges. Expect `out_valid = 0` and `a = 0` immediately. After release, the first new vector emerges with correct latency and the pre-reset vectors never appear.
- Wrap-around: `y = {0, 0, 0, 0}`, `b = {1, 128, 255, 0}`. Expect `a = {255, 128, 1, 0}` and `borrow = {1, 1, 1, 0}`.
